// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline control unit for the five-stage RISC-V core. Produces every
// stall/bubble strobe for the IF/ID/EX/MEM/WB pipe registers from three
// sources, in priority order:
//   M : data-memory wait (IDLE/WAIT/ERR state machine with timeout)
//   H : data hazard (load-use, branch operand from EX, branch operand from a
//       load still in MEM)
//   R : ID-stage redirect (pc_src_id), which flushes the wrong-path fetch
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> three saturating performance counters are built
//   undefined -> counter outputs tie to 0, no counter flops
//
// Parameters
//   REG_AW   register-address width
//   MAX_WAIT consecutive unacked WAIT cycles before timeout (1..255)
//   CNT_W    performance counter width
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   rs1_id, rs2_id                ID source registers
//   rs1_use_id, rs2_use_id        ID instruction really reads rs1/rs2
//   branch_id                     ID instruction resolves in ID
//   pc_src_id                     ID redirect taken
//   rd_ex, reg_write_ex,
//   mem_read_ex                   EX destination info
//   rd_mem, mem_read_mem          MEM destination info
//   mem_req, mem_ack              data-memory access / completion
//   stall_if..stall_wb            hold pipe register
//   bubble_if..bubble_wb          load NOP into pipe register
//   mem_timeout                   sticky timeout error (1 in ERR)
//   cnt_load_use, cnt_mem_wait,
//   cnt_flush                     performance counters
//   fsm_state                     memory FSM state (0 IDLE, 1 WAIT, 2 ERR)
//
// Memory handshake: mem_req is held high by the MEM stage for the whole
// access; mem_ack pulses high for exactly the cycle in which the memory
// completes it. An ack in the same cycle as the first request cycle
// completes the access with no wait. There is no separate ready signal:
// while an access is outstanding the pipeline is frozen by the M stall.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_use_id,
  input  logic              rs2_use_id,
  input  logic              branch_id,
  input  logic              pc_src_id,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              reg_write_ex,
  input  logic              mem_read_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              mem_read_mem,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              stall_wb,
  output logic              bubble_if,
  output logic              bubble_id,
  output logic              bubble_ex,
  output logic              bubble_mem,
  output logic              bubble_wb,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  cnt_load_use,
  output logic [CNT_W-1:0]  cnt_mem_wait,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  mem_state_t state;
  logic [7:0] wait_cnt;

  // ---------------------------------------------------------------------------
  // Register match rule: x0 never creates a dependency, and a source that the
  // ID instruction does not read cannot either.
  // ---------------------------------------------------------------------------
  logic match_ex;
  logic match_mem;
  logic hazard;
  logic mem_stall;

  always_comb begin
    match_ex  = (rd_ex != '0) &&
                ((rs1_use_id && (rd_ex == rs1_id)) ||
                 (rs2_use_id && (rd_ex == rs2_id)));
    match_mem = (rd_mem != '0) &&
                ((rs1_use_id && (rd_mem == rs1_id)) ||
                 (rs2_use_id && (rd_mem == rs2_id)));
  end

  // Load-use always stalls; branches resolved in ID additionally need any EX
  // result (not yet forwardable to ID) and any load still in MEM.
  assign hazard = (mem_read_ex && match_ex) ||
                  (branch_id && reg_write_ex && match_ex) ||
                  (branch_id && mem_read_mem && match_mem);

  // ---------------------------------------------------------------------------
  // Memory wait state machine. wait_cnt counts WAIT cycles, starting at 1 in
  // the first WAIT cycle, so ERR is entered on the edge that closes the
  // MAX_WAIT-th unacked WAIT cycle. An ack always wins over the timeout.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_req && !mem_ack) begin
            state    <= ST_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == MAX_WAIT_C) begin
            state       <= ST_ERR;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ERR: begin
          // Terminal until reset.
          mem_timeout <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          wait_cnt    <= 8'd0;
          mem_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

  always_comb begin
    case (state)
      ST_IDLE: mem_stall = mem_req && !mem_ack;
      ST_WAIT: mem_stall = !mem_ack;
      ST_ERR:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Strobe generation. The memory stall freezes IF..MEM and drains WB with a
  // bubble; a data hazard freezes IF/ID and injects a bubble into EX; a
  // redirect only squashes the fetched instruction entering ID. Everything is
  // forced quiet while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    stall_wb   = 1'b0;
    bubble_if  = 1'b0;
    bubble_id  = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    bubble_wb  = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        bubble_wb = 1'b1;
      end else if (hazard) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (pc_src_id) begin
        bubble_id = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic hazard_cycle;
  assign hazard_cycle = hazard && !mem_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_load_use <= '0;
      cnt_mem_wait <= '0;
      cnt_flush    <= '0;
    end else begin
      if (hazard_cycle && (cnt_load_use != '1))
        cnt_load_use <= cnt_load_use + CNT_ONE;
      if (mem_stall && (cnt_mem_wait != '1))
        cnt_mem_wait <= cnt_mem_wait + CNT_ONE;
      if (bubble_id && (cnt_flush != '1))
        cnt_flush <= cnt_flush + CNT_ONE;
    end
  end
`else
  assign cnt_load_use = '0;
  assign cnt_mem_wait = '0;
  assign cnt_flush    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl (MAX_WAIT=4, CNT_W=4). Stimulus is a
// linear sequence of cycles; inputs change 1 ns after the rising edge and
// outputs are sampled on the falling edge. Counter expectations come from a
// tally of the expected strobe patterns, saturating at 15, and are zero when
// HAZARD_PERF_CNT_EN is not defined.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  // {stall_if,stall_id,stall_ex,stall_mem,stall_wb,
  //  bubble_if,bubble_id,bubble_ex,bubble_mem,bubble_wb}
  localparam logic [9:0] P_NONE  = 10'b00000_00000;
  localparam logic [9:0] P_MEM   = 10'b11110_00001;
  localparam logic [9:0] P_HAZ   = 10'b11000_00100;
  localparam logic [9:0] P_FLUSH = 10'b00000_01000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] rs1_id, rs2_id, rd_ex, rd_mem;
  logic rs1_use_id, rs2_use_id, branch_id, pc_src_id;
  logic reg_write_ex, mem_read_ex, mem_read_mem, mem_req, mem_ack;
  logic stall_if, stall_id, stall_ex, stall_mem, stall_wb;
  logic bubble_if, bubble_id, bubble_ex, bubble_mem, bubble_wb;
  logic mem_timeout;
  logic [CNT_W-1:0] cnt_load_use, cnt_mem_wait, cnt_flush;
  logic [1:0] fsm_state;
  logic [9:0] strobes;

  assign strobes = {stall_if, stall_id, stall_ex, stall_mem, stall_wb,
                    bubble_if, bubble_id, bubble_ex, bubble_mem, bubble_wb};

  pipe_hazard_ctrl #(
    .REG_AW  (REG_AW),
    .MAX_WAIT(4),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_use_id  (rs1_use_id),
    .rs2_use_id  (rs2_use_id),
    .branch_id   (branch_id),
    .pc_src_id   (pc_src_id),
    .rd_ex       (rd_ex),
    .reg_write_ex(reg_write_ex),
    .mem_read_ex (mem_read_ex),
    .rd_mem      (rd_mem),
    .mem_read_mem(mem_read_mem),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .stall_mem   (stall_mem),
    .stall_wb    (stall_wb),
    .bubble_if   (bubble_if),
    .bubble_id   (bubble_id),
    .bubble_ex   (bubble_ex),
    .bubble_mem  (bubble_mem),
    .bubble_wb   (bubble_wb),
    .mem_timeout (mem_timeout),
    .cnt_load_use(cnt_load_use),
    .cnt_mem_wait(cnt_mem_wait),
    .cnt_flush   (cnt_flush),
    .fsm_state   (fsm_state)
  );

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  int t_lu = 0;
  int t_mw = 0;
  int t_fl = 0;

  function automatic int sat_inc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(v);
`else
    return (v == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe check; also tallies the expected pattern for the counter model.
  // Called exactly once per driven cycle.
  task automatic chk_strobes(input string tag, input logic [9:0] exp);
    chk(tag, 32'(strobes), 32'(exp));
    if (exp == P_HAZ)   t_lu = sat_inc(t_lu);
    if (exp == P_MEM)   t_mw = sat_inc(t_mw);
    if (exp == P_FLUSH) t_fl = sat_inc(t_fl);
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_lu"}, 32'(cnt_load_use), exp_cnt(t_lu));
    chk({tag, "_mw"}, 32'(cnt_mem_wait), exp_cnt(t_mw));
    chk({tag, "_fl"}, 32'(cnt_flush),    exp_cnt(t_fl));
  endtask

  // driver tasks
  task automatic clear_inputs();
    rs1_id = '0; rs2_id = '0; rd_ex = '0; rd_mem = '0;
    rs1_use_id = 1'b0; rs2_use_id = 1'b0; branch_id = 1'b0; pc_src_id = 1'b0;
    reg_write_ex = 1'b0; mem_read_ex = 1'b0; mem_read_mem = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_load_use(input logic [4:0] rd);
    mem_read_ex = 1'b1; rd_ex = rd; rs1_id = 5'd5; rs1_use_id = 1'b1;
  endtask

  initial begin
    // ---------------- reset ----------------
    clear_inputs();
    mem_req = 1'b1;                // must be masked while reset is low
    drive_load_use(5'd5);
    sample();
    chk_strobes("rst_strobes", P_NONE);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
    chk_cnts("rst_cnt");
    clear_inputs();
    rst = 1'b1;

    // ---------------- load-use ----------------
    next_cycle(); clear_inputs(); drive_load_use(5'd5); sample();
    chk_strobes("lu_hit", P_HAZ);
    next_cycle(); clear_inputs(); sample();
    chk_strobes("lu_one_cycle", P_NONE);
    next_cycle(); clear_inputs(); drive_load_use(5'd0); rs1_id = 5'd0; sample();
    chk_strobes("lu_x0", P_NONE);
    next_cycle(); clear_inputs(); drive_load_use(5'd5); rs1_use_id = 1'b0; sample();
    chk_strobes("lu_no_use", P_NONE);
    // branch operand produced by an ALU op in EX, via rs2
    next_cycle(); clear_inputs();
    branch_id = 1'b1; rs2_id = 5'd3; rs2_use_id = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd3;
    sample();
    chk_strobes("br_ex", P_HAZ);
    next_cycle(); branch_id = 1'b0; sample();
    chk_strobes("alu_no_branch", P_NONE);

    // ---------------- branch operand from a load ----------------
    next_cycle(); clear_inputs();
    branch_id = 1'b1; rs2_id = 5'd7; rs2_use_id = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd7;
    sample();
    chk_strobes("brld_c1", P_HAZ);
    next_cycle(); mem_read_ex = 1'b0; rd_ex = 5'd0; mem_read_mem = 1'b1; rd_mem = 5'd7;
    sample();
    chk_strobes("brld_c2", P_HAZ);
    next_cycle(); mem_read_mem = 1'b0; rd_mem = 5'd0; pc_src_id = 1'b1; sample();
    chk_strobes("brld_c3_flush", P_FLUSH);

    // ---------------- memory wait of 3 cycles ----------------
    next_cycle(); clear_inputs(); mem_req = 1'b1; sample();
    chk_strobes("mw_c1", P_MEM);
    chk("mw_c1_state", 32'(fsm_state), 32'(S_IDLE));
    next_cycle(); sample();
    chk_strobes("mw_c2", P_MEM);
    chk("mw_c2_state", 32'(fsm_state), 32'(S_WAIT));
    next_cycle(); sample();
    chk_strobes("mw_c3", P_MEM);
    next_cycle(); mem_ack = 1'b1; sample();
    chk_strobes("mw_ack", P_NONE);
    next_cycle(); clear_inputs(); sample();
    chk_strobes("mw_idle", P_NONE);
    chk("mw_back_idle", 32'(fsm_state), 32'(S_IDLE));
    chk("mw_cnt", 32'(cnt_mem_wait), exp_cnt(t_mw));

    // ack in the request cycle costs nothing
    next_cycle(); mem_req = 1'b1; mem_ack = 1'b1; sample();
    chk_strobes("mw_zero", P_NONE);
    next_cycle(); clear_inputs(); sample();
    chk_strobes("mw_zero_after", P_NONE);
    chk("mw_zero_state", 32'(fsm_state), 32'(S_IDLE));

    // ---------------- priority: M over H over redirect ----------------
    next_cycle(); clear_inputs(); mem_req = 1'b1; drive_load_use(5'd5); pc_src_id = 1'b1;
    sample();
    chk_strobes("prio_c1", P_MEM);
    next_cycle(); sample();
    chk_strobes("prio_c2", P_MEM);
    next_cycle(); mem_ack = 1'b1; sample();
    chk_strobes("prio_ack_haz", P_HAZ);
    next_cycle(); clear_inputs(); sample();
    chk_strobes("prio_idle", P_NONE);
    chk_cnts("cnt_mid");

    // ---------------- flush held 20 cycles (counter saturation) ----------------
    for (int i = 0; i < 20; i++) begin
      next_cycle(); clear_inputs(); pc_src_id = 1'b1; sample();
      chk_strobes("flush_hold", P_FLUSH);
    end
    next_cycle(); clear_inputs(); sample();
    chk_strobes("flush_done", P_NONE);
    chk("flush_sat", 32'(cnt_flush), exp_cnt(15));
    chk_cnts("cnt_sat");

    // ---------------- timeout (MAX_WAIT = 4) ----------------
    next_cycle(); clear_inputs(); mem_req = 1'b1; sample();
    chk_strobes("to_idle", P_MEM);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); sample();
      chk_strobes("to_wait", P_MEM);
      chk("to_not_yet", 32'(mem_timeout), 32'd0);
    end
    next_cycle(); sample();
    chk_strobes("to_err", P_MEM);
    chk("to_flag", 32'(mem_timeout), 32'd1);
    chk("to_state", 32'(fsm_state), 32'(S_ERR));
    next_cycle(); clear_inputs(); sample();
    chk_strobes("to_err_hold", P_MEM);
    chk("to_flag_hold", 32'(mem_timeout), 32'd1);

    // asynchronous reset in the middle of ERR
    #2 rst = 1'b0;
    #1;
    t_lu = 0; t_mw = 0; t_fl = 0;
    chk("arst_timeout", 32'(mem_timeout), 32'd0);
    chk("arst_strobes", 32'(strobes), 32'(P_NONE));
    chk("arst_state", 32'(fsm_state), 32'(S_IDLE));
    chk_cnts("arst_cnt");
    next_cycle(); rst = 1'b1; sample();
    chk_strobes("post_rst", P_NONE);
    chk("post_rst_timeout", 32'(mem_timeout), 32'd0);
    next_cycle(); drive_load_use(5'd5); sample();
    chk_strobes("post_rst_lu", P_HAZ);
    next_cycle(); clear_inputs(); sample();
    chk_strobes("post_rst_idle", P_NONE);
    chk_cnts("cnt_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline control unit for the five-stage RISC-V core. It generates every `stall_*`/`bubble_*` strobe for the IF/ID/EX/MEM/WB pipe registers. It combines load-use and ID-stage branch-operand hazard detection with a multi-cycle data-memory wait state machine that includes timeout. Optional saturating performance counters are included. It replaces the purely combinational hazard detection so the core can run against data memories with variable latency.

## Interface
- `REG_AW`, default 5: register-address width.
- `MAX_WAIT`, default 15: maximum consecutive memory-wait cycles before timeout; legal range 1..255.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rs1_id`, `rs2_id`  in  REG_AW  source registers of the instruction in ID.
- `rs1_use_id`, `rs2_use_id`  in  1  the ID instruction actually reads rs1/rs2.
- `branch_id`  in  1  ID instruction resolves in ID (branch or jalr) and needs operands there.
- `pc_src_id`  in  1  ID redirect taken (branch taken, jal, or jalr).
- `rd_ex`  in  REG_AW; `reg_write_ex`, `mem_read_ex`  in  1  EX-stage destination info.
- `rd_mem`  in  REG_AW; `mem_read_mem`  in  1  MEM-stage destination info.
- `mem_req`  in  1  MEM stage is accessing data memory (load or store).
- `mem_ack`  in  1  data memory completes the access this cycle.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`, `stall_wb`  out  1  hold the pipe register.
- `bubble_if`, `bubble_id`, `bubble_ex`, `bubble_mem`, `bubble_wb`  out  1  load a NOP into the pipe register.
- `mem_timeout`  out  1  sticky memory-timeout error.
- `cnt_load_use`, `cnt_mem_wait`, `cnt_flush`  out  CNT_W  performance counters.

## Operation
- **Match rule:** a match exists when the `rdX` value is not x0, equals `rsN_id`, and `rsN_use_id` is 1.
- **Hazard H (data hazard), combinational.** H is asserted when any of the following holds:
  - load-use: `mem_read_ex` and a match on `rd_ex`;
  - `branch_id`, `reg_write_ex`, and a match on `rd_ex`;
  - `branch_id`, `mem_read_mem`, and a match on `rd_mem`.
- **Memory FSM states:**
  - IDLE → WAIT when `mem_req & !mem_ack`.
  - WAIT → IDLE when `mem_ack`.
  - WAIT → ERR when the wait counter reaches MAX_WAIT without `mem_ack`.
  - ERR is terminal until reset.
- **Memory stall M:** asserted in IDLE when `mem_req & !mem_ack`, in WAIT when `!mem_ack`, and always in ERR.
- **Outputs, evaluated in priority order:**
  1. M: `stall_if`/`stall_id`/`stall_ex`/`stall_mem` = 1, `bubble_wb` = 1, all other strobes 0.
  2. H (M = 0): `stall_if`/`stall_id` = 1, `bubble_ex` = 1.
  3. `pc_src_id` (M = 0, H = 0): `bubble_id` = 1, which flushes the wrong-path fetch. `pc_src_id` during H is ignored.
  4. Otherwise all strobes are 0.
- `bubble_if` and `stall_wb` are always 0.
- **Wait counter:** 8 bits. Loads 1 on the IDLE→WAIT transition and increments each WAIT cycle. Timeout fires when the counter equals MAX_WAIT while still not acked. A `mem_ack` in the same cycle wins over timeout.
- `mem_timeout` = 1 in ERR.

## Timing
- Hazard and redirect strobes are combinational from the current-cycle inputs, with zero latency.
- The memory-stall strobes are combinational from the FSM state and `mem_req`/`mem_ack`.
- A load-use or branch-on-EX hazard stalls for exactly 1 cycle, because the producer advances.
- A branch-on-load hazard costs 2 cycles: first EX, then MEM.
- Memory wait of k cycles stalls for exactly k cycles. An ack in the request cycle costs 0.
- Timeout: ERR is entered on the edge after the MAX_WAIT-th unacked WAIT cycle.
- **Reset** (`rst` = 0, asynchronous):
  - FSM goes to IDLE, wait counter to 0, `mem_timeout` to 0, and all counters to 0.
  - While `rst` is low, all stall and bubble outputs are forced to 0.
  - Reset asserted in WAIT or ERR aborts the access. Deassertion is sampled synchronously.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: the three counters are updated as follows, each saturating at all-ones:
  - `cnt_load_use` +1 per cycle with H asserted and M = 0;
  - `cnt_mem_wait` +1 per cycle with M asserted;
  - `cnt_flush` +1 per cycle with `bubble_id` asserted.
- `HAZARD_PERF_CNT_EN` undefined: counter outputs are constant 0 and no counter flops are built. The ports remain present.

## Test plan
- **Load-use hazard.** `mem_read_ex`=1, `rd_ex`=5, `rs1_id`=5, `rs1_use_id`=1 for 1 cycle → `stall_if`=`stall_id`=`bubble_ex`=1 for that cycle only. The same stimulus with `rd_ex`=0 → all strobes 0.
- **Branch operand from a load.** `branch_id`=1 with `rs2_id`=7; cycle 1 `mem_read_ex`, `rd_ex`=7; cycle 2 `mem_read_mem`, `rd_mem`=7 → stall for 2 cycles, then cycle 3 with `pc_src_id`=1 → `bubble_id`=1.
- **Memory wait.** `mem_req`=1 with `mem_ack` low for 3 cycles, then high → `stall_if..mem`=1 and `bubble_wb`=1 for exactly 3 cycles, FSM returns to IDLE, `cnt_mem_wait`=3.
- **Priority.** M and H both active, with `pc_src_id`=1 → only the memory-stall pattern appears and `bubble_ex`=0; after the ack, H applies.
- **Timeout.** MAX_WAIT=4, `mem_req` held with no ack → `mem_timeout`=1 after the 4th WAIT cycle and stays 1 with all stalls held. Asserting `rst`=0 mid-ERR → `mem_timeout`=0 immediately and strobes 0.
- **Counter saturation.** With `HAZARD_PERF_CNT_EN` defined and CNT_W=4, hold a flush for 20 cycles → `cnt_flush`=15. With the macro undefined → `cnt_flush`=0.
